// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: ping-pong 8x8 transpose buffer between the row and column DCT stages.
// Rows are written column-major into one bank while the other bank is presented in parallel.
module dct_transpose_buf #(
    parameter int SIZE = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_sob,
    input  logic                            approx_en_in,
    input  logic signed [7:0][SIZE-1:0]      data_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [7:0][7:0][SIZE-1:0] data_out,
    output logic                            approx_en_out,
    output logic                            err_align
);
    logic [7:0][7:0][SIZE-1:0] mem_q [2];
    logic [1:0] full_q, full_d, approx_q, approx_d;
    logic       wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, err_q, err_d;
    logic [2:0] wr_row_q, wr_row_d, row;
    logic       accept, rel;

    always_comb begin
        in_ready = !full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        accept = in_valid && in_ready;
        rel = out_valid && out_ready;
        // a start-of-block restarts the current bank at row 0, dropping the partial block
        row = in_sob ? 3'd0 : wr_row_q;
        wr_row_d = accept ? row + 3'd1 : wr_row_q;
        wr_bank_d = wr_bank_q ^ (accept && row == 3'd7);
        rd_bank_d = rd_bank_q ^ rel;
        err_d = accept && in_sob && wr_row_q != 3'd0;
        full_d = full_q;
        if (rel) full_d[rd_bank_q] = 1'b0;
        if (accept && row == 3'd7) full_d[wr_bank_q] = 1'b1;
        approx_d = approx_q;
        if (accept && row == 3'd0) approx_d[wr_bank_q] = approx_en_in;
        data_out = mem_q[rd_bank_q];
        approx_en_out = approx_q[rd_bank_q];
        err_align = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            full_q <= '0;
            approx_q <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept)
                for (int c = 0; c < 8; c++)
                    mem_q[wr_bank_q][c][row] <= data_in[c];
            full_q <= full_d;
            approx_q <= approx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q <= wr_row_d;
            err_q <= err_d;
        end
    end
endmodule

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
- Sits between the row-DCT stage and the combinational column stage (8 column instances, 8x8 parallel input).
- Accepts one 8-sample row per handshake and assembles a transposed 8x8 block.
- Presents the block in parallel as column-major data for the column stage.
- Ping-pong double buffering lets the upstream keep streaming rows while the downstream holds a finished block.

Parameters:
- SIZE, 10, signed sample width; same for input rows and output block.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  row valid
- in_ready  out  1  buffer can accept a row
- in_sob  in  1  start-of-block; marks row 0 of a block
- approx_en_in  in  1  approximation mode; sampled with each block's row 0
- data_in  in  [7:0] x SIZE signed  one row; data_in[c] is column c
- out_valid  out  1  full transposed block available
- out_ready  in  1  downstream accepts block
- data_out  out  [7:0][7:0] x SIZE signed  data_out[i][j] = element i of row j, so data_out[i] is column i
- approx_en_out  out  1  approx_en captured with the presented block
- err_align  out  1  one-cycle pulse on block misalignment

Behaviour:
- Storage:
  - Two banks B0/B1, each 64 x SIZE registers plus a full flag and an approx bit.
  - wr_bank pointer, rd_bank pointer, 3-bit row counter wr_row.
- Reset (async, rst=1):
  - wr_bank=rd_bank=0, wr_row=0, both banks empty, all data and approx bits 0.
  - Outputs: out_valid=0, data_out=0, approx_en_out=0, err_align=0.
  - in_ready=1 as soon as reset deasserts.
- Write side:
  - in_ready = !full[wr_bank]. Purely a function of registered state; no combinational path from out_ready.
  - Accept when in_valid && in_ready: bank[wr_bank][c][wr_row] <= data_in[c] for c=0..7.
  - When wr_row==0, also capture approx_en_in into the bank's approx bit.
  - wr_row increments; on the accept with wr_row==7, wr_row wraps to 0, full[wr_bank]<=1, and wr_bank toggles.
- Alignment:
  - in_sob accepted with wr_row!=0: the partial block is discarded.
    - The row is written as row 0 of the same bank and wr_row becomes 1.
    - err_align pulses the next cycle.
  - in_sob=0 with wr_row==0 is legal; the row is treated as row 0 with no error.
- Read side:
  - out_valid = full[rd_bank].
  - data_out and approx_en_out are a direct mux of bank[rd_bank]; they stay stable while out_valid=1 and out_ready=0.
  - When out_valid=0, data_out shows the stale contents of rd_bank. Consumers must qualify with out_valid.
  - On out_valid && out_ready: full[rd_bank]<=0 and rd_bank toggles.
- Latency: out_valid rises the cycle after row 7 of a block is accepted.
- Throughput:
  - One row per cycle sustained when out_ready is held high.
  - One block per 8 cycles.
- Simultaneous events:
  - Completing bank X while releasing bank Y in the same cycle: both updates apply.
  - If wr_bank==rd_bank and that bank is full, in_ready=0 that cycle even if out_ready=1. Acceptance resumes next cycle (one bubble).
- Backpressure: with both banks full, in_ready=0 and data_in is ignored; no state changes on the write side.
- Reset mid-block: partial rows are lost, and both banks return to empty immediately (asynchronous).

Test Plan:
- Single block:
  - Stimulus: reset, then 8 rows with in_sob on row 0, data_in[c] = 8*r+c, out_ready=1.
  - Required: out_valid one cycle after row 7; data_out[i][j] = 8*j+i (e.g. data_out[3][5]=43).
- Streaming:
  - Stimulus: 4 back-to-back blocks with distinct bases (0, 100, 200, 300), in_valid and out_ready held 1.
  - Required: in_ready stays 1; blocks appear in order, 8 cycles apart.
- Backpressure:
  - Stimulus: out_ready=0 while 3 blocks are sent.
  - Required: after 16 rows in_ready=0; block 1 is held stable; raising out_ready releases block 1, then block 2.
  - Required: the third block is accepted only after a bank frees, with a one-cycle bubble when wr_bank==rd_bank.
- Misalignment:
  - Stimulus: in_sob on row 5 of a block.
  - Required: err_align pulse of one cycle; the next 7 rows complete a block whose row 0 is the sob row.
- Approx tag:
  - Stimulus: approx_en_in=1 for block A and 0 for block B, with approx_en_in toggled during rows 1-7.
  - Required: approx_en_out = 1 then 0, matching each block's row-0 value.
- Reset mid-block:
  - Stimulus: assert rst after 4 rows.
  - Required: out_valid=0 and data_out=0 immediately; a following full block is output correctly with no remnants of the partial block.
